// File: rtl/ooo_pkg.sv
// Shared types and widths for the out-of-order front end.
// The instruction buffer entry layout lives here so fetch, the buffer and
// dispatch all agree on field order and width.
package ooo_pkg;

    localparam int OPCODE_W  = 4;
    localparam int REG_W     = 4;
    localparam int ROB_IDX_W = 4;
    localparam int ISSUE_W   = 4;

    // One decoded instruction as held in the buffer (26 bits).
    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;
        logic [REG_W-1:0]     rt;
        logic [REG_W-1:0]     ra;
        logic [REG_W-1:0]     rb;
        logic                 a_dep;
        logic [ROB_IDX_W-1:0] a_owner;
        logic                 b_dep;
        logic [ROB_IDX_W-1:0] b_owner;
    } ib_entry_t;

    localparam int IB_ENTRY_W = $bits(ib_entry_t);

    // Number of instructions actually removed this cycle: the request is
    // saturated to the issue width and then to the current occupancy, so a
    // dequeue can never run past the valid entries.
    function automatic int unsigned deq_effective(input int unsigned req,
                                                  input int unsigned occupancy);
        int unsigned r;
        r = (req > ISSUE_W) ? ISSUE_W : req;
        return (r > occupancy) ? occupancy : r;
    endfunction

endpackage

// File: rtl/ib_storage.sv
// Circular entry array for the instruction buffer.
// Four write ports land a whole fetch group at consecutive (wrapping)
// addresses; four combinational read ports expose head..head+3.
// The array is deliberately not reset: validity is tracked by the
// controller's occupancy count, never by the data itself.
module ib_storage
    import ooo_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  ib_entry_t        wr_data [ISSUE_W],
    input  logic [PTR_W-1:0] rd_ptr,
    output ib_entry_t        rd_data [ISSUE_W]
);

    ib_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_addr [ISSUE_W];
    logic [PTR_W-1:0] rd_addr [ISSUE_W];

    // Consecutive slot addresses; pointer arithmetic wraps naturally because
    // DEPTH is a power of two.
    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            wr_addr[k] = wr_ptr + PTR_W'(k);
            rd_addr[k] = rd_ptr + PTR_W'(k);
        end
    end

    // Write the whole group in one edge; groups are never partially written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < ISSUE_W; k++) begin
                mem[wr_addr[k]] <= wr_data[k];
            end
        end
    end

    // Combinational read of the four oldest positions.
    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            rd_data[k] = mem[rd_addr[k]];
        end
    end

endmodule

// File: rtl/instr_buffer.sv
// Instruction buffer between fetch and dispatch.
// Accepts one 4-wide decoded group per cycle when at least four entries are
// free, presents the oldest four instructions in program order, and lets
// dispatch consume 0..4 of them per cycle. A taken jump empties it.
//
// Handshake: a group transfers on a rising edge where in_valid && in_ready
// && !flush; in_ready depends only on registered occupancy, so fetch may
// hold in_valid high with stable data until it sees in_ready. On the output
// side out_valid[k] marks slot k as holding a real instruction, and dispatch
// reports how many it took with deq_cnt (there is no per-slot ready).
//
// Owner tag width is ooo_pkg::ROB_IDX_W, shared with the ROB.
module instr_buffer
    import ooo_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPCODE_W-1:0]  in_opcode  [ISSUE_W],
    input  logic [REG_W-1:0]     in_rt      [ISSUE_W],
    input  logic [REG_W-1:0]     in_ra      [ISSUE_W],
    input  logic [REG_W-1:0]     in_rb      [ISSUE_W],
    input  logic                 in_a_dep   [ISSUE_W],
    input  logic                 in_b_dep   [ISSUE_W],
    input  logic [ROB_IDX_W-1:0] in_a_owner [ISSUE_W],
    input  logic [ROB_IDX_W-1:0] in_b_owner [ISSUE_W],

    output logic                 out_valid   [ISSUE_W],
    output logic [OPCODE_W-1:0]  out_opcode  [ISSUE_W],
    output logic [REG_W-1:0]     out_rt      [ISSUE_W],
    output logic [REG_W-1:0]     out_ra      [ISSUE_W],
    output logic [REG_W-1:0]     out_rb      [ISSUE_W],
    output logic                 out_a_dep   [ISSUE_W],
    output logic                 out_b_dep   [ISSUE_W],
    output logic [ROB_IDX_W-1:0] out_a_owner [ISSUE_W],
    output logic [ROB_IDX_W-1:0] out_b_owner [ISSUE_W],

    input  logic [2:0]           deq_cnt,
    output logic [CNT_W-1:0]     count,
    output logic                 empty,
    output logic                 full
);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] eff;
    logic             enq;

    ib_entry_t        wr_data [ISSUE_W];
    ib_entry_t        rd_data [ISSUE_W];

    // Room for a full group is judged on registered occupancy only, so a
    // dequeue in the same cycle cannot create a path from deq_cnt to in_ready.
    always_comb begin
        in_ready = (count_q <= CNT_W'(DEPTH - ISSUE_W));
        full     = !in_ready;
        empty    = (count_q == '0);
        count    = count_q;
    end

    // Accepted-enqueue and effective-dequeue amounts; flush overrides both.
    always_comb begin
        enq        = in_valid && in_ready && !flush;
        eff        = CNT_W'(deq_effective(32'(deq_cnt), 32'(count_q)));
        count_next = count_q + (enq ? CNT_W'(ISSUE_W) : '0) - eff;
    end

    // Pointer and occupancy registers; flush clears them like reset does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + PTR_W'(eff);
            if (enq) begin
                tail <= tail + PTR_W'(ISSUE_W);
            end
            count_q <= count_next;
        end
    end

    // Pack the incoming group into storage entries; fields are kept verbatim.
    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            wr_data[k].opcode  = in_opcode[k];
            wr_data[k].rt      = in_rt[k];
            wr_data[k].ra      = in_ra[k];
            wr_data[k].rb      = in_rb[k];
            wr_data[k].a_dep   = in_a_dep[k];
            wr_data[k].a_owner = in_a_owner[k];
            wr_data[k].b_dep   = in_b_dep[k];
            wr_data[k].b_owner = in_b_owner[k];
        end
    end

    ib_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk     (clk),
        .wr_en   (enq),
        .wr_ptr  (tail),
        .wr_data (wr_data),
        .rd_ptr  (head),
        .rd_data (rd_data)
    );

    // Unpack head..head+3 onto the dispatch-facing ports; slot k is valid
    // only while at least k+1 instructions are held.
    always_comb begin
        for (int k = 0; k < ISSUE_W; k++) begin
            out_valid[k]   = (count_q > CNT_W'(k));
            out_opcode[k]  = rd_data[k].opcode;
            out_rt[k]      = rd_data[k].rt;
            out_ra[k]      = rd_data[k].ra;
            out_rb[k]      = rd_data[k].rb;
            out_a_dep[k]   = rd_data[k].a_dep;
            out_a_owner[k] = rd_data[k].a_owner;
            out_b_dep[k]   = rd_data[k].b_dep;
            out_b_owner[k] = rd_data[k].b_owner;
        end
    end

endmodule

// File: tb/tb_instr_buffer.sv
// Directed bench for instr_buffer (DEPTH=16).
module tb_instr_buffer;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opcode  [4];
  logic [3:0] in_rt      [4];
  logic [3:0] in_ra      [4];
  logic [3:0] in_rb      [4];
  logic       in_a_dep   [4];
  logic       in_b_dep   [4];
  logic [3:0] in_a_owner [4];
  logic [3:0] in_b_owner [4];
  logic       out_valid  [4];
  logic [3:0] out_opcode [4];
  logic [3:0] out_rt     [4];
  logic [3:0] out_ra     [4];
  logic [3:0] out_rb     [4];
  logic       out_a_dep  [4];
  logic       out_b_dep  [4];
  logic [3:0] out_a_owner[4];
  logic [3:0] out_b_owner[4];
  logic [2:0] deq_cnt;
  logic [4:0] count;
  logic       empty;
  logic       full;

  int total = 0;
  int bad   = 0;
  logic [25:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  instr_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rt(in_rt), .in_ra(in_ra), .in_rb(in_rb),
    .in_a_dep(in_a_dep), .in_b_dep(in_b_dep),
    .in_a_owner(in_a_owner), .in_b_owner(in_b_owner),
    .out_valid(out_valid), .out_opcode(out_opcode), .out_rt(out_rt),
    .out_ra(out_ra), .out_rb(out_rb), .out_a_dep(out_a_dep),
    .out_b_dep(out_b_dep), .out_a_owner(out_a_owner), .out_b_owner(out_b_owner),
    .deq_cnt(deq_cnt), .count(count), .empty(empty), .full(full)
  );

  // Expected instruction for sequence number seq, field order
  // {opcode, rt, ra, rb, a_dep, a_owner, b_dep, b_owner}.
  function automatic logic [25:0] make_entry(input int seq);
    logic [7:0] s;
    logic [3:0] lo;
    logic [3:0] hi;
    s  = seq[7:0];
    lo = s[3:0];
    hi = s[7:4];
    return {lo, hi, ~lo, hi ^ 4'h5, s[0], lo + 4'h1, s[1], hi + 4'h3};
  endfunction

  function automatic logic [25:0] obs_entry(input int k);
    return {out_opcode[k], out_rt[k], out_ra[k], out_rb[k],
            out_a_dep[k], out_a_owner[k], out_b_dep[k], out_b_owner[k]};
  endfunction

  function automatic logic [3:0] valid_vec();
    return {out_valid[3], out_valid[2], out_valid[1], out_valid[0]};
  endfunction

  // driver tasks
  task automatic drive_group(input int base);
    logic [25:0] e;
    for (int s = 0; s < 4; s++) begin
      e = make_entry(base + s);
      in_opcode[s]  = e[25:22];
      in_rt[s]      = e[21:18];
      in_ra[s]      = e[17:14];
      in_rb[s]      = e[13:10];
      in_a_dep[s]   = e[9];
      in_a_owner[s] = e[8:5];
      in_b_dep[s]   = e[4];
      in_b_owner[s] = e[3:0];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1; in_valid = 1'b0; deq_cnt = 3'd0;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b expected 1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b expected 0", full); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    total++; if (valid_vec() !== 4'b0000) begin bad++; $display("FAIL reset_out_valid: got %b expected 0000", valid_vec()); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int g = 0; g < 4; g++) begin
      drive_group(g * 4); in_valid = 1'b1;
      tick();
      total++; if (count !== 5'(4 * (g + 1))) begin bad++; $display("FAIL fill_count: got %0d expected %0d", count, 4 * (g + 1)); end
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full: got %b expected 1", full); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
    drive_group(100); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (count !== 5'd16) begin bad++; $display("FAIL fill_held_count: got %0d expected 16", count); end
    for (int g = 0; g < 4; g++) begin
      for (int s = 0; s < 4; s++) begin
        total++; if (obs_entry(s) !== make_entry(g * 4 + s)) begin bad++; $display("FAIL fill_drain_data: got %h expected %h", obs_entry(s), make_entry(g * 4 + s)); end
      end
      deq_cnt = 3'd4;
      tick();
    end
    deq_cnt = 3'd0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fill_drain_empty: got %b expected 1", empty); end
  endtask

  task automatic test_order();
    logic [3:0] exp_vec [5];
    exp_vec[0] = 4'b1111; exp_vec[1] = 4'b0111; exp_vec[2] = 4'b0011;
    exp_vec[3] = 4'b0001; exp_vec[4] = 4'b0000;
    do_flush();
    drive_group(40);
    for (int s = 0; s < 4; s++) in_opcode[s] = 4'(s + 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (valid_vec() !== exp_vec[i]) begin bad++; $display("FAIL order_valid[%0d]: got %b expected %b", i, valid_vec(), exp_vec[i]); end
      if (i < 4) begin
        total++; if (out_opcode[0] !== 4'(i + 1)) begin bad++; $display("FAIL order_opcode[%0d]: got %0d expected %0d", i, out_opcode[0], i + 1); end
      end
      deq_cnt = 3'd1;
      tick();
    end
    deq_cnt = 3'd0;
  endtask

  task automatic test_full_deq();
    do_flush();
    in_valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
      drive_group(200 + g * 4);
      tick();
    end
    drive_group(216);
    deq_cnt = 3'd4;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fulldeq_in_ready: got %b expected 0", in_ready); end
    tick();
    total++; if (count !== 5'd12) begin bad++; $display("FAIL fulldeq_count1: got %0d expected 12", count); end
    total++; if (obs_entry(0) !== make_entry(204)) begin bad++; $display("FAIL fulldeq_head1: got %h expected %h", obs_entry(0), make_entry(204)); end
    tick();
    in_valid = 1'b0; deq_cnt = 3'd0;
    total++; if (count !== 5'd12) begin bad++; $display("FAIL fulldeq_count2: got %0d expected 12", count); end
    total++; if (obs_entry(0) !== make_entry(208)) begin bad++; $display("FAIL fulldeq_head2: got %h expected %h", obs_entry(0), make_entry(208)); end
    total++; if (obs_entry(3) !== make_entry(211)) begin bad++; $display("FAIL fulldeq_slot3: got %h expected %h", obs_entry(3), make_entry(211)); end
  endtask

  // scoreboard-driven wrap test: 10 groups, dequeue 4 every other cycle
  task automatic test_wrap();
    int sent = 0;
    int cyc = 0;
    int mcount = 0;
    int got = 0;
    int d;
    int eff;
    bit enq;
    logic [25:0] exp_e;
    do_flush();
    exp_q.delete();
    while ((sent < 10 || mcount > 0) && cyc < 200) begin
      enq = (sent < 10) && (mcount <= 12);
      if (enq) begin
        drive_group(300 + sent * 4);
        for (int s = 0; s < 4; s++) exp_q.push_back(make_entry(300 + sent * 4 + s));
        sent++;
      end
      in_valid = enq;
      d = (cyc % 2 == 1) ? 4 : 0;
      deq_cnt = 3'(d);
      eff = (d > mcount) ? mcount : d;
      for (int k = 0; k < 4; k++) begin
        total++; if (out_valid[k] !== (k < mcount)) begin bad++; $display("FAIL wrap_valid[%0d]: got %b expected %b", k, out_valid[k], k < mcount); end
      end
      for (int k = 0; k < eff; k++) begin
        exp_e = exp_q.pop_front();
        got++;
        total++; if (obs_entry(k) !== exp_e) begin bad++; $display("FAIL wrap_data: got %h expected %h", obs_entry(k), exp_e); end
      end
      tick();
      mcount = mcount + (enq ? 4 : 0) - eff;
      total++; if (count !== 5'(mcount)) begin bad++; $display("FAIL wrap_count: got %0d expected %0d", count, mcount); end
      cyc++;
    end
    in_valid = 1'b0; deq_cnt = 3'd0;
    total++; if (got !== 40) begin bad++; $display("FAIL wrap_total: got %0d expected 40", got); end
  endtask

  task automatic test_underflow();
    do_flush();
    drive_group(400); in_valid = 1'b1;
    tick();
    in_valid = 1'b0; deq_cnt = 3'd2;
    tick();
    total++; if (count !== 5'd2) begin bad++; $display("FAIL under_count2: got %0d expected 2", count); end
    total++; if (obs_entry(0) !== make_entry(402)) begin bad++; $display("FAIL under_head: got %h expected %h", obs_entry(0), make_entry(402)); end
    deq_cnt = 3'd4;
    tick();
    total++; if (count !== 5'd0) begin bad++; $display("FAIL under_count0: got %0d expected 0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL under_empty: got %b expected 1", empty); end
    total++; if (valid_vec() !== 4'b0000) begin bad++; $display("FAIL under_valid: got %b expected 0000", valid_vec()); end
    tick();
    deq_cnt = 3'd0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL under_again: got %0d expected 0", count); end
  endtask

  task automatic test_flush_reset();
    do_flush();
    in_valid = 1'b1;
    drive_group(500); tick();
    drive_group(504); tick();
    drive_group(508); deq_cnt = 3'd2; tick();
    total++; if (count !== 5'd10) begin bad++; $display("FAIL flush_pre_count: got %0d expected 10", count); end
    drive_group(512); flush = 1'b1; deq_cnt = 3'd3;
    tick();
    flush = 1'b0; in_valid = 1'b0; deq_cnt = 3'd0;
    total++; if (count !== 5'd0) begin bad++; $display("FAIL flush_count: got %0d expected 0", count); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL flush_empty: got %b expected 1", empty); end
    total++; if (valid_vec() !== 4'b0000) begin bad++; $display("FAIL flush_valid: got %b expected 0000", valid_vec()); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    in_valid = 1'b1;
    drive_group(520); tick();
    drive_group(524); tick();
    in_valid = 1'b0;
    total++; if (count !== 5'd8) begin bad++; $display("FAIL rst_pre_count: got %0d expected 8", count); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (valid_vec() !== 4'b0000) begin bad++; $display("FAIL rst_async_valid: got %b expected 0000", valid_vec()); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_async_in_ready: got %b expected 1", in_ready); end
    total++; if (count !== 5'd0) begin bad++; $display("FAIL rst_async_count: got %0d expected 0", count); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive_group(600); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (count !== 5'd4) begin bad++; $display("FAIL rst_after_count: got %0d expected 4", count); end
    total++; if (obs_entry(0) !== make_entry(600)) begin bad++; $display("FAIL rst_after_head: got %h expected %h", obs_entry(0), make_entry(600)); end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; deq_cnt = 3'd0;
    drive_group(0);
    test_reset();
    test_fill();
    test_order();
    test_full_deq();
    test_wrap();
    test_underflow();
    test_flush_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
